// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: one-op-per-cycle read/write sequencer for a shared FIFO.
// Optional LEVEL_CNT_EN adds a local occupancy counter and flag cross-check.
module fifo_access_ctrl #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int MAX_RD_BURST = 4,
  parameter int DEPTH        = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rd_req,
  output logic                      rd_ready,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      fifo_write_n,
  output logic                      fifo_read_n,
  output logic [DATA_W-1:0]         fifo_data_in,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  input  logic [DATA_W-1:0]         fifo_data_out
`ifdef LEVEL_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       level_err
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] win_idx;
  logic          win_hit;
  logic [3:0]    rd_streak;
  logic          rd_elig;
  logic          wr_pend;
  logic          wr_elig;
  logic          burst_ok;
  logic          rd_gnt;
  logic          wr_gnt;
  logic          lvl_nf;
  logic          lvl_ne;

`ifdef LEVEL_CNT_EN
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  assign lvl_nf = (level != LVL_MAX);
  assign lvl_ne = (level != '0);
`else
  assign lvl_nf = 1'b1;
  assign lvl_ne = 1'b1;
`endif

  // Eligibility and read-vs-write decision; nothing is granted in reset.
  always_comb begin
    wr_pend  = |req_valid;
    rd_elig  = rd_req & ~fifo_empty & lvl_ne;
    wr_elig  = wr_pend & ~fifo_full & lvl_nf;
    burst_ok = (rd_streak < 4'(MAX_RD_BURST));
    rd_gnt   = reset & rd_elig & (~wr_elig | burst_ok);
    wr_gnt   = reset & wr_elig & ~rd_gnt;
  end

  // Round-robin scan starting just after the last granted producer.
  always_comb begin
    win_idx = '0;
    win_hit = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_hit &&
          req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        win_hit = 1'b1;
        win_idx = IW'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  // Drive handshakes, strobes and write data from the grants.
  always_comb begin
    req_ready    = '0;
    fifo_data_in = '0;
    if (wr_gnt && win_hit) begin
      req_ready[win_idx] = 1'b1;
      fifo_data_in = req_data[int'(win_idx)*DATA_W +: DATA_W];
    end
    rd_ready     = rd_gnt;
    fifo_read_n  = rd_gnt;
    fifo_write_n = wr_gnt;
    rd_data      = fifo_data_out;
  end

  // Read data from the FIFO is valid the cycle after the read strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_valid <= 1'b0;
    else        rd_valid <= rd_gnt;
  end

  // Remember the last writer; producer 0 gets first priority after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_grant <= IW'(NUM_REQ-1);
    else if (wr_gnt) last_grant <= win_idx;
  end

  // Count reads granted while a writer waits, to bound the read burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rd_streak <= '0;
    else if (!wr_pend || wr_gnt)
      rd_streak <= '0;
    else if (rd_gnt && rd_streak != 4'hF)
      rd_streak <= rd_streak + 4'd1;
  end

`ifdef LEVEL_CNT_EN
  // Local occupancy count tracking our own grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      level <= '0;
    else if (wr_gnt) level <= level + LW'(1);
    else if (rd_gnt) level <= level - LW'(1);
  end

  // Sticky flag when the FIFO's flags disagree with the local count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      level_err <= 1'b0;
    else if ((fifo_empty && level != '0) ||
             (fifo_full && level != LVL_MAX))
      level_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb_fifo_access_ctrl: directed plus random checks of fifo_access_ctrl
// against a queue-based reference model and a behavioural FIFO.
module tb_fifo_access_ctrl;

  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;
  localparam int D = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          rd_req;
  logic          rd_ready;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          fifo_write_n;
  logic          fifo_read_n;
  logic [W-1:0]  fifo_data_in;
  logic          fifo_full;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data_out;
`ifdef LEVEL_CNT_EN
  logic [3:0]    level;
  logic          level_err;
`endif

  fifo_access_ctrl #(
    .NUM_REQ(N), .DATA_W(W), .MAX_RD_BURST(B), .DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .rd_req(rd_req),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .fifo_write_n(fifo_write_n),
    .fifo_read_n(fifo_read_n),
    .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out)
`ifdef LEVEL_CNT_EN
    ,
    .level(level),
    .level_err(level_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  int         m_last;
  int         m_streak;
  int         m_level;
  logic       m_rdv;
  logic       m_err;
  logic [7:0] m_rdata;
  logic [7:0] ref_q[$];

  // behavioural FIFO driven by the DUT strobes
  logic [7:0] fq[$];
  bit         ovr_full;
  bit         ovr_empty;

  // DUT outputs captured mid-cycle
  logic [3:0] cap_rr;
  logic       cap_rd;
  logic       cap_wr;
  logic [7:0] cap_din;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_flags();
    fifo_empty = ovr_empty || (fq.size() == 0);
    fifo_full  = ovr_full || (fq.size() >= D);
  endtask

  task automatic model_reset();
    m_last   = N - 1;
    m_streak = 0;
    m_level  = 0;
    m_rdv    = 1'b0;
    m_err    = 1'b0;
    fq.delete();
    ref_q.delete();
  endtask

  task automatic step();
    bit         rde;
    bit         wre;
    bit         pend;
    bit         e_rd;
    bit         e_wr;
    bit         err_hit;
    int         win;
    logic [3:0] e_rr;
    logic [7:0] e_din;
    @(negedge clk);
    pend = |req_valid;
    rde  = rd_req && !fifo_empty;
    wre  = pend && !fifo_full;
`ifdef LEVEL_CNT_EN
    rde = rde && (m_level != 0);
    wre = wre && (m_level != D);
`endif
    e_rd = reset && rde && (!wre || m_streak < B);
    e_wr = reset && wre && !e_rd;
    win  = 0;
    for (int k = N; k >= 1; k--)
      if (req_valid[(m_last + k) % N]) win = (m_last + k) % N;
    e_rr  = e_wr ? 4'(1 << win) : 4'd0;
    e_din = e_wr ? req_data[win*W +: W] : 8'd0;
    err_hit = (fifo_empty && m_level != 0) ||
              (fifo_full && m_level != D);
    chk("req_ready", req_ready, e_rr);
    chk("rd_ready", rd_ready, e_rd);
    chk("fifo_read_n", fifo_read_n, e_rd);
    chk("fifo_write_n", fifo_write_n, e_wr);
    chk("fifo_data_in", fifo_data_in, e_din);
    chk("rd_valid", rd_valid, reset && m_rdv);
    if (reset && m_rdv) chk("rd_data", rd_data, m_rdata);
`ifdef LEVEL_CNT_EN
    chk("level", level, m_level);
    chk("level_err", level_err, m_err);
`endif
    cap_rr  = req_ready;
    cap_rd  = fifo_read_n;
    cap_wr  = fifo_write_n;
    cap_din = fifo_data_in;
    @(posedge clk);
    #1;
    if (!reset) begin
      model_reset();
    end else begin
      m_rdv = e_rd;
      if (e_rd)
        m_rdata = (ref_q.size() > 0) ? ref_q.pop_front() : 8'h00;
      if (e_wr) begin
        ref_q.push_back(e_din);
        m_last = win;
      end
      if (!pend || e_wr) m_streak = 0;
      else if (e_rd && m_streak < 15) m_streak++;
      if (e_wr) m_level++;
      if (e_rd) m_level--;
      if (err_hit) m_err = 1'b1;
      if (cap_rd && fq.size() > 0) fifo_data_out = fq.pop_front();
      if (cap_wr && fq.size() < D) fq.push_back(cap_din);
    end
    upd_flags();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ovr_full = 1'b0;
    ovr_empty = 1'b0;
    req_valid = '0;
    rd_req = 1'b0;
    upd_flags();
    step();
    step();
    reset = 1'b1;
    upd_flags();
  endtask

  logic [3:0] rr_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [9:0] burst_exp = 10'b1111011110;

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_data = '0;
    rd_req = 1'b0;
    fifo_data_out = '0;
    ovr_full = 1'b0;
    ovr_empty = 1'b0;
    model_reset();
    upd_flags();
    #1;
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_req_ready", req_ready, 4'b0000);
    do_reset();

    // round-robin over all four producers
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      req_data = $urandom;
      step();
      chk("rr_seq", cap_rr, rr_exp[i]);
    end
    for (int i = 0; i < 3; i++) begin
      req_data = $urandom;
      step();
    end

    // read priority with bounded burst
    req_valid = 4'b0100;
    rd_req = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      req_data = $urandom;
      step();
      chk("burst_rd", cap_rd, burst_exp[i]);
    end

    // full: producers held, then producer 0 wins
    do_reset();
    req_valid = 4'b1111;
    ovr_full = 1'b1;
    upd_flags();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("full_hold", cap_wr, 1'b0);
    end
    ovr_full = 1'b0;
    upd_flags();
    step();
    chk("full_release", cap_rr, 4'b0001);

    // empty: read blocked, write 0xA5, then read it back
    do_reset();
    rd_req = 1'b1;
    step();
    chk("empty_rd", cap_rd, 1'b0);
    rd_req = 1'b0;
    req_valid = 4'b0010;
    req_data = 32'h0000_A500;
    step();
    chk("empty_wr", cap_rr, 4'b0010);
    req_valid = 4'b0000;
    rd_req = 1'b1;
    step();
    chk("empty_rd_gnt", cap_rd, 1'b1);
    rd_req = 1'b0;
    chk("rd_valid_a5", rd_valid, 1'b1);
    chk("rd_data_a5", rd_data, 8'hA5);

    // asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    chk("async_rd_valid", rd_valid, 1'b0);
    chk("async_wr_n", fifo_write_n, 1'b0);
    chk("async_rd_n", fifo_read_n, 1'b0);
    model_reset();
    upd_flags();
    step();
    reset = 1'b1;
    req_valid = 4'b1111;
    step();
    chk("post_reset_rr", cap_rr, 4'b0001);

`ifdef LEVEL_CNT_EN
    do_reset();
    req_valid = 4'b0001;
    step();
    step();
    step();
    req_valid = 4'b0000;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("level_2", level, 4'd2);
    ovr_empty = 1'b1;
    upd_flags();
    step();
    step();
    chk("level_err_set", level_err, 1'b1);
    ovr_empty = 1'b0;
    upd_flags();
    step();
    chk("level_err_sticky", level_err, 1'b1);
`endif

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req_valid = 4'($urandom);
      req_data  = $urandom;
      if (i < 300) rd_req = ($urandom_range(0, 3) == 0);
      else         rd_req = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_access_ctrl.md
Name: fifo_access_ctrl

Overview:
- Sequences the shared single-port-per-cycle FIFO.
- Arbitrates NUM_REQ producer write requests, round-robin, against one consumer read port.
- Issues at most one FIFO operation per cycle, read or write, never both.
- Read has priority, with a bounded burst so producers cannot starve; sits directly in front of the FIFO's strobe, data and flag pins.

Parameters:
- NUM_REQ, 4: number of producer ports, 2..8.
- DATA_W, 8: data width, equal to the FIFO width.
- MAX_RD_BURST, 4: consecutive read grants allowed while a write is pending before one write is forced; 1..15.
- DEPTH, 15: usable FIFO entries; only used under LEVEL_CNT_EN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  producer i has a word
- req_data  in  NUM_REQ*DATA_W  producer i word at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot accept; transfer occurs when valid&ready
- rd_req  in  1  consumer requests a word
- rd_ready  out  1  read accepted this cycle
- rd_valid  out  1  rd_data valid; registered, one cycle after rd_ready
- rd_data  out  DATA_W  direct from fifo_data_out
- fifo_write_n  out  1  active-high write strobe to FIFO
- fifo_read_n  out  1  active-high read strobe to FIFO
- fifo_data_in  out  DATA_W  granted producer word, 0 when no write
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_data_out  in  DATA_W  FIFO read data

Behaviour:
- Reset (reset=0, async): rd_valid=0, rd_streak=0, last_grant=NUM_REQ-1 (producer 0 has first priority).
- Combinational outputs evaluate to no grant while reset=0: req_ready=0, rd_ready=0, fifo_write_n=0, fifo_read_n=0, fifo_data_in=0.
- Eligibility each cycle:
  - rd_elig = rd_req & !fifo_empty
  - wr_pend = |req_valid
  - wr_elig = wr_pend & !fifo_full
- Decision (combinational, same cycle):
  - rd_elig and !wr_elig: read.
  - wr_elig and !rd_elig: write.
  - Both eligible: read if rd_streak < MAX_RD_BURST, else write.
  - Neither eligible: idle.
- Read grant: rd_ready=1 and fifo_read_n=1 in the same cycle; rd_valid=1 in the next cycle, rd_data=fifo_data_out.
- Write grant: the winner is the first i with req_valid[i], scanning last_grant+1 upward with wrap mod NUM_REQ. req_ready[i]=1, fifo_write_n=1 and fifo_data_in=req_data slice i, all in the same cycle; last_grant<=i at the edge.
- rd_streak (registered, saturating):
  - +1 on a read grant while wr_pend.
  - Cleared on a write grant, or on any cycle with !wr_pend.
  - Held on idle cycles with wr_pend=1, e.g. while the FIFO is full.
- fifo_read_n and fifo_write_n are never both 1 in a cycle.
- Flags are used combinationally; the FIFO updates them the cycle after an operation, so back-to-back operations are legal.
- Full: producers are held (req_ready=0); reads continue and rd_streak does not force a write.
- Empty: rd_ready=0; writes proceed.
- A producer dropping req_valid without ready loses nothing; the scan simply skips it.
- Reset asserted mid-operation: the pending rd_valid is cleared immediately; no FIFO strobe is issued while reset=0.

Optional Feature:
- Macro: LEVEL_CNT_EN.
- When defined:
  - Adds output level [$clog2(DEPTH+1)-1:0], reset 0: +1 on a write grant, -1 on a read grant.
  - Write eligibility uses (level != DEPTH) & !fifo_full.
  - Read eligibility uses (level != 0) & !fifo_empty.
  - Adds output level_err, sticky, reset 0: set if fifo_empty=1 while level!=0, or fifo_full=1 while level!=DEPTH.
- When undefined: no level or level_err ports; gating uses the FIFO flags only.

Test Plan:
- Round-robin: reset, then req_valid=4'b1111 held, fifo empty, rd_req=0 → req_ready sequence 0001, 0010, 0100, 1000, 0001; fifo_data_in tracks the granted slice.
- Read priority and starvation bound (MAX_RD_BURST=4): FIFO holding 8 words, rd_req=1 and req_valid=4'b0100 held → 4 read grants, 1 write to producer 2, then 4 reads again; rd_valid follows each rd_ready by exactly 1 cycle.
- Full: fifo_full=1, req_valid=4'b1111, rd_req=0 → req_ready=0 and fifo_write_n=0 indefinitely; after fifo_full=0, producer 0 is granted on the next cycle.
- Empty: fifo_empty=1, rd_req=1 → rd_ready=0, fifo_read_n=0; write 0xA5 from producer 1, then fifo_empty=0 → read granted and rd_data=0xA5 with rd_valid=1 one cycle later.
- Async reset: assert reset=0 mid-cycle with rd_valid=1 → rd_valid drops immediately without a clock edge; after release, the first write grant goes to producer 0.
- LEVEL_CNT_EN: 3 writes then 1 read → level=2; force fifo_empty=1 while level=2 → level_err=1 and stays 1 until reset.
